rr_resource_arbiter: RTL

- Two-requester round-robin arbiter and sequencer for one shared resource.
- A granted requester owns the resource for exactly BUSY_CYCLES clocks. The arbiter then pulses done, takes one mandatory idle cycle and re-arbitrates.
- Fixed grant latency and fixed hold time make every transaction checkable with simple SVA implications of the "trigger |-> x ##N y" form.
- Sits between the requester logic and the shared datapath.

---
 rtl/arb_pkg.sv | 20 ++
 rtl/rr_resource_arbiter_sva.sv | 63 ++++++
 rtl/rr_resource_arbiter.sv | 98 +++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared types and the round-robin pick function for the two-requester resource arbiter.
package arb_pkg;

  typedef enum logic [1:0] {IDLE, HOLD, DONE} arb_state_t;
  typedef enum logic {OWN_A, OWN_B} owner_t;

  // With both requesters contending, the one that did not own last wins.
  function automatic owner_t rr_pick(input logic req_a, input logic req_b, input owner_t owner);
    owner_t pick;
    if (req_a && req_b) begin
      pick = (owner == OWN_A) ? OWN_B : OWN_A;
    end else if (req_a) begin
      pick = OWN_A;
    end else begin
      pick = OWN_B;
    end
    return pick;
  endfunction

endpackage

// File: rtl/rr_resource_arbiter_sva.sv
// Protocol checker for rr_resource_arbiter, attached to every instance by the bind below.
module rr_resource_arbiter_sva
  import arb_pkg::*;
#(
  parameter int unsigned BUSY_CYCLES = 3,
  parameter int unsigned CNT_W       = $clog2(BUSY_CYCLES + 1)
) (
  input logic             clk,
  input logic             rst_n,
  input logic             req_a,
  input logic             req_b,
  input logic             gnt_a,
  input logic             gnt_b,
  input logic             busy,
  input logic             done,
  input logic             owner,
  input logic [CNT_W-1:0] busy_cnt,
  input arb_state_t       state
);

  // Consecutive sampled cycles with a grant asserted; width covers the full legal hold range.
  logic [8:0] r_run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run <= '0;
    end else if (gnt_a || gnt_b) begin
      r_run <= r_run + 9'd1;
    end else begin
      r_run <= '0;
    end
  end

  a_mutex: assert property (@(posedge clk) disable iff (!rst_n) !(gnt_a && gnt_b));
  a_busy_eq: assert property (@(posedge clk) disable iff (!rst_n) busy == (gnt_a || gnt_b));
  a_done_idle: assert property (@(posedge clk) disable iff (!rst_n) !(done && busy));
  a_hold_short: assert property (@(posedge clk) disable iff (!rst_n) busy |-> (r_run < 9'(BUSY_CYCLES)));
  a_hold_len: assert property (@(posedge clk) disable iff (!rst_n)
    $fell(busy) |-> (done && (r_run == 9'(BUSY_CYCLES))));
  a_done_gap: assert property (@(posedge clk) disable iff (!rst_n) done |=> !(gnt_a || gnt_b));
  a_cnt_range: assert property (@(posedge clk) disable iff (!rst_n) 32'(busy_cnt) < BUSY_CYCLES);
  a_rr_alt: assert property (@(posedge clk) disable iff (!rst_n)
    (state == IDLE && req_a && req_b) |=>
      ((gnt_a == $past(owner)) && (gnt_b != $past(owner)) && (owner != $past(owner))));

endmodule

bind rr_resource_arbiter rr_resource_arbiter_sva #(
  .BUSY_CYCLES(BUSY_CYCLES),
  .CNT_W      (CNT_W)
) u_sva (
  .clk     (clk),
  .rst_n   (rst_n),
  .req_a   (req_a),
  .req_b   (req_b),
  .gnt_a   (gnt_a),
  .gnt_b   (gnt_b),
  .busy    (busy),
  .done    (done),
  .owner   (owner),
  .busy_cnt(busy_cnt),
  .state   (r_state)
);

// File: rtl/rr_resource_arbiter.sv
// Two-requester round-robin arbiter: fixed BUSY_CYCLES ownership, done pulse, one idle cycle.
module rr_resource_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned BUSY_CYCLES = 3,
  parameter int unsigned CNT_W       = $clog2(BUSY_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_a,
  input  logic             req_b,
  output logic             gnt_a,
  output logic             gnt_b,
  output logic             busy,
  output logic             done,
  output logic             owner,
  output logic [CNT_W-1:0] busy_cnt
);

  arb_state_t       r_state, w_state;
  owner_t           r_owner, w_owner, w_pick;
  logic             r_gnt_a, w_gnt_a;
  logic             r_gnt_b, w_gnt_b;
  logic             r_busy, w_busy;
  logic             r_done, w_done;
  logic [CNT_W-1:0] r_cnt, w_cnt;

  // Owner resets to B so A wins the first contested arbitration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_owner <= OWN_B;
      r_gnt_a <= 1'b0;
      r_gnt_b <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state;
      r_owner <= w_owner;
      r_gnt_a <= w_gnt_a;
      r_gnt_b <= w_gnt_b;
      r_busy  <= w_busy;
      r_done  <= w_done;
      r_cnt   <= w_cnt;
    end
  end

  // Next state and next registered outputs; requests are only looked at in IDLE.
  always_comb begin
    w_state = r_state;
    w_owner = r_owner;
    w_gnt_a = r_gnt_a;
    w_gnt_b = r_gnt_b;
    w_busy  = r_busy;
    w_done  = 1'b0;
    w_cnt   = r_cnt;
    w_pick  = rr_pick(req_a, req_b, r_owner);
    case (r_state)
      IDLE: begin
        if (req_a || req_b) begin
          w_owner = w_pick;
          w_gnt_a = (w_pick == OWN_A);
          w_gnt_b = (w_pick == OWN_B);
          w_busy  = 1'b1;
          w_cnt   = CNT_W'(BUSY_CYCLES - 1);
          w_state = HOLD;
        end
      end
      HOLD: begin
        // A zero count on entry (BUSY_CYCLES == 1) releases on the very next edge.
        if (r_cnt != '0) begin
          w_cnt = r_cnt - CNT_W'(1);
        end else begin
          w_gnt_a = 1'b0;
          w_gnt_b = 1'b0;
          w_busy  = 1'b0;
          w_done  = 1'b1;
          w_state = DONE;
        end
      end
      DONE: begin
        w_state = IDLE;
      end
      default: begin
        w_state = IDLE;
      end
    endcase
  end

  assign gnt_a    = r_gnt_a;
  assign gnt_b    = r_gnt_b;
  assign busy     = r_busy;
  assign done     = r_done;
  assign owner    = r_owner;
  assign busy_cnt = r_cnt;

endmodule
